// File: rtl/port_rd_pkg.sv
// Shared types and constants for the per-port read scheduler.
package port_rd_pkg;

    localparam int unsigned DEF_NUM_QUEUES = 8;
    localparam int unsigned DEF_WEIGHT_W   = 4;

    typedef enum logic {
        SCAN   = 1'b0,
        RELOAD = 1'b1
    } state_e;

    function automatic int unsigned qid_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-index-first priority encoder: index of the lowest set request bit.
module prio_enc_lsb #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req_i[i] && !any_o) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_rd_wrr_sched.sv
// Per-port read scheduler: strict priority or credit-based WRR over NUM_QUEUES queues.
// Optional round counter enabled by defining PORT_RD_WRR_STATS_EN.
module port_rd_wrr_sched
    import port_rd_pkg::*;
#(
    parameter int unsigned NUM_QUEUES = DEF_NUM_QUEUES,
    parameter int unsigned WEIGHT_W   = DEF_WEIGHT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wrr_en,
    input  logic [NUM_QUEUES*WEIGHT_W-1:0] weight,
    input  logic [NUM_QUEUES-1:0]          queue_empty,
    input  logic                           prior_update,
    output logic [qid_w(NUM_QUEUES)-1:0]   prior_next,
    output logic                           prior_valid,
    output logic [15:0]                    round_cnt
);

    localparam int unsigned QID_W = qid_w(NUM_QUEUES);

    state_e              state_q, state_d;
    logic [WEIGHT_W-1:0] credit_q [NUM_QUEUES];
    logic [WEIGHT_W-1:0] credit_d [NUM_QUEUES];
    logic [QID_W-1:0]    prior_next_q, prior_next_d;
    logic                prior_valid_q, prior_valid_d;
    logic                init_q;

    logic [NUM_QUEUES-1:0] elig;
    logic [QID_W-1:0]      sel_idx;
    logic                  sel_any;
    logic                  upd_ok;
    logic                  reload_all;

    always_comb begin
        for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            elig[i] = ~queue_empty[i] & (~wrr_en | (credit_q[i] != '0));
        end
    end

    prio_enc_lsb #(
        .WIDTH (NUM_QUEUES),
        .IDX_W (QID_W)
    ) u_enc (
        .req_i (elig),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    assign upd_ok     = prior_update & prior_valid_q;
    // init_q makes the first post-reset edge load credits from the live weights
    assign reload_all = init_q | ~wrr_en | (state_q == RELOAD);

    always_comb begin
        state_d       = SCAN;
        prior_next_d  = sel_idx;
        prior_valid_d = sel_any & ~upd_ok & ~init_q & (state_q == SCAN);
        case (state_q)
            SCAN:    if (wrr_en && !init_q && !sel_any && !(&queue_empty)) state_d = RELOAD;
            RELOAD:  state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            credit_d[i] = credit_q[i];
            if (reload_all) begin
                credit_d[i] = (weight[i*WEIGHT_W +: WEIGHT_W] == '0) ? WEIGHT_W'(1)
                                                                      : weight[i*WEIGHT_W +: WEIGHT_W];
            end else if (upd_ok && (prior_next_q == QID_W'(i)) && (credit_q[i] != '0)) begin
                credit_d[i] = credit_q[i] - WEIGHT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SCAN;
            prior_next_q  <= '0;
            prior_valid_q <= 1'b0;
            init_q        <= 1'b1;
            for (int unsigned i = 0; i < NUM_QUEUES; i++) credit_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            prior_next_q  <= prior_next_d;
            prior_valid_q <= prior_valid_d;
            init_q        <= 1'b0;
            for (int unsigned i = 0; i < NUM_QUEUES; i++) credit_q[i] <= credit_d[i];
        end
    end

    assign prior_next  = prior_next_q;
    assign prior_valid = prior_valid_q;

`ifdef PORT_RD_WRR_STATS_EN
    logic [15:0] round_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_cnt_q <= '0;
        end else if (state_q == RELOAD) begin
            round_cnt_q <= round_cnt_q + 16'd1;
        end
    end

    assign round_cnt = round_cnt_q;
`else
    assign round_cnt = '0;
`endif

endmodule

// File: tb/tb_port_rd_wrr_sched.sv
// Directed self-checking bench for port_rd_wrr_sched (8 queues, 4-bit weights).
module tb_port_rd_wrr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wrr_en = 1'b0;
    logic [31:0] weight = 32'h1111_1111;
    logic [7:0]  queue_empty = 8'hFF;
    logic        prior_update = 1'b0;
    logic [2:0]  prior_next;
    logic        prior_valid;
    logic [15:0] round_cnt;

    int checks = 0;
    int errors = 0;

    port_rd_wrr_sched #(
        .NUM_QUEUES (8),
        .WEIGHT_W   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wrr_en       (wrr_en),
        .weight       (weight),
        .queue_empty  (queue_empty),
        .prior_update (prior_update),
        .prior_next   (prior_next),
        .prior_valid  (prior_valid),
        .round_cnt    (round_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wrr;
        logic [7:0] qe;
        logic [2:0] exp_next;
        logic       exp_valid;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic mode, input logic [31:0] w, input logic [7:0] qe);
        rst = 1'b1;
        wrr_en = mode;
        weight = w;
        queue_empty = qe;
        prior_update = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a valid selection, consumes it, and reports the index and wait cycles.
    task automatic grant(input string name, output int q, output int waits);
        waits = 0;
        while (!prior_valid && waits < 20) begin
            tick();
            waits++;
        end
        if (!prior_valid) begin
            chk({name, "_timeout"}, 0, 1);
            q = -1;
        end else begin
            q = int'(prior_next);
            prior_update = 1'b1;
            tick();
            prior_update = 1'b0;
            chk({name, "_valid_drop"}, int'(prior_valid), 0);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   q, w;
        int   exp_seq[8];
        int   exp_rounds;

        vecs[0] = '{1'b0, 8'hFF,        3'd0, 1'b0};
        vecs[1] = '{1'b0, 8'b1111_0101, 3'd1, 1'b1};
        vecs[2] = '{1'b0, 8'b1111_1110, 3'd0, 1'b1};
        vecs[3] = '{1'b0, 8'b0111_1111, 3'd7, 1'b1};
        vecs[4] = '{1'b0, 8'b1000_0000, 3'd0, 1'b1};
        vecs[5] = '{1'b0, 8'b1110_1111, 3'd4, 1'b1};
        vecs[6] = '{1'b1, 8'hFF,        3'd0, 1'b0};
        vecs[7] = '{1'b1, 8'b1111_1011, 3'd2, 1'b1};

        // Reset state and table of combinational-to-registered selections
        do_reset(1'b0, 32'h1111_1111, 8'hFF);
        chk("reset_valid", int'(prior_valid), 0);
        chk("reset_next", int'(prior_next), 0);
        chk("reset_round_cnt", int'(round_cnt), 0);
        for (int i = 0; i < 8; i++) begin
            wrr_en = vecs[i].wrr;
            queue_empty = vecs[i].qe;
            tick();
            tick();
            chk($sformatf("vec%0d_valid", i), int'(prior_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_next", i), int'(prior_next), int'(vecs[i].exp_next));
        end

        // Asynchronous reset mid-stream
        wrr_en = 1'b0;
        queue_empty = 8'b1111_0111;
        tick();
        tick();
        chk("pre_rst_valid", int'(prior_valid), 1);
        chk("pre_rst_next", int'(prior_next), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(prior_valid), 0);
        chk("async_rst_next", int'(prior_next), 0);
        queue_empty = 8'hFF;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_empty_valid", int'(prior_valid), 0);

        // Strict priority with repeated updates
        do_reset(1'b0, 32'h1111_1111, 8'b1111_0101);
        for (int i = 0; i < 5; i++) begin
            grant($sformatf("strict%0d", i), q, w);
            chk($sformatf("strict%0d_q", i), q, 1);
        end

        // WRR q0=3, q1=1: two full rounds
        exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
        do_reset(1'b1, 32'h2222_2213, 8'b1111_1100);
        for (int i = 0; i < 8; i++) begin
            grant($sformatf("wrr%0d", i), q, w);
            chk($sformatf("wrr%0d_q", i), q, exp_seq[i]);
            if (i == 1) chk("wrr_mid_round_wait", w, 1);
            if (i == 4) chk("wrr_reload_wait", w, 3);
        end
        for (int i = 0; i < 4; i++) tick();
`ifdef PORT_RD_WRR_STATS_EN
        exp_rounds = 2;
`else
        exp_rounds = 0;
`endif
        chk("wrr_round_cnt", int'(round_cnt), exp_rounds);

        // Weight 0 behaves as weight 1
        do_reset(1'b1, 32'h1111_1011, 8'b1111_1011);
        for (int i = 0; i < 3; i++) begin
            grant($sformatf("w0_%0d", i), q, w);
            chk($sformatf("w0_%0d_q", i), q, 2);
            if (i > 0) chk($sformatf("w0_%0d_wait", i), w, 3);
        end

        // Mid-round empty with q0 refilled before reload
        do_reset(1'b1, 32'h1111_2112, 8'b1111_0110);
        grant("mid0", q, w);
        chk("mid0_q", q, 0);
        queue_empty = 8'b1111_0111;
        grant("mid1", q, w);
        chk("mid1_q", q, 3);
        chk("mid1_wait", w, 1);
        queue_empty = 8'b1111_0110;
        grant("mid2", q, w);
        chk("mid2_q", q, 0);
        grant("mid3", q, w);
        chk("mid3_q", q, 3);
        grant("mid4", q, w);
        chk("mid4_q", q, 0);
        chk("mid4_wait", w, 3);

        // Mode toggle: exhausted q0 regains priority and full weight
        do_reset(1'b1, 32'h1111_1122, 8'b1111_1100);
        grant("tog0", q, w);
        chk("tog0_q", q, 0);
        grant("tog1", q, w);
        chk("tog1_q", q, 0);
        wrr_en = 1'b0;
        grant("tog_strict", q, w);
        chk("tog_strict_q", q, 0);
        chk("tog_strict_wait", w, 1);
        wrr_en = 1'b1;
        exp_seq = '{0, 0, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            grant($sformatf("tog_wrr%0d", i), q, w);
            chk($sformatf("tog_wrr%0d_q", i), q, exp_seq[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
